// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - memory-stage access bus between pipeline and data memory
interface data_mem_if;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic        mem_write_m;
  logic        mem_read_m;
  logic [2:0]  funct3_m;
  logic [31:0] read_data_m;
  logic        access_fault_m;

  modport master (
    output alu_result_m, write_data_m, mem_write_m, mem_read_m, funct3_m,
    input  read_data_m, access_fault_m
  );

  modport slave (
    input  alu_result_m, write_data_m, mem_write_m, mem_read_m, funct3_m,
    output read_data_m, access_fault_m
  );
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory with combinational reads, byte/half/word stores and fault capture
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  data_mem_if.slave   bus,
  output logic        fault_sticky,
  output logic [31:0] fault_addr
);
  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + SPAN;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      addr;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             in_range;
  logic             is_half;
  logic             is_word;
  logic             misaligned;
  logic             load_ok;
  logic             store_ok;
  logic             bad_funct3;
  logic             fault;
  logic             commit;
  logic [31:0]      word;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      rdata_dec;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lane;
  logic [31:0]      merged;
  logic             unused_offset_bits;

  assign addr   = bus.alu_result_m;
  assign offset = addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];
  assign lane   = addr[1:0];
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  // 33-bit compare so the upper bound cannot wrap for bases near the top of the map
  assign in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);

  assign is_half    = (bus.funct3_m[1:0] == 2'b01);
  assign is_word    = (bus.funct3_m[1:0] == 2'b10);
  assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

  always_comb begin
    load_ok  = 1'b0;
    store_ok = 1'b0;
    case (bus.funct3_m)
      3'b000, 3'b001, 3'b010: begin
        load_ok  = 1'b1;
        store_ok = 1'b1;
      end
      3'b100, 3'b101: load_ok = 1'b1;
      default: ;
    endcase
  end

  // The store rule is the stricter one, so it governs a combined read+write
  assign bad_funct3 = bus.mem_write_m ? !store_ok : !load_ok;
  assign fault      = (bus.mem_read_m || bus.mem_write_m) &&
                      (misaligned || !in_range || bad_funct3);
  assign bus.access_fault_m = fault;

  assign word = mem[idx];

  always_comb begin
    sel_byte = word[7:0];
    case (lane)
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
  end

  assign sel_half = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    rdata_dec = 32'h0;
    case (bus.funct3_m)
      3'b000:  rdata_dec = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  rdata_dec = {{16{sel_half[15]}}, sel_half};
      3'b010:  rdata_dec = word;
      3'b100:  rdata_dec = {24'h0, sel_byte};
      3'b101:  rdata_dec = {16'h0, sel_half};
      default: rdata_dec = 32'h0;
    endcase
  end

  assign bus.read_data_m = (!in_range || (bus.mem_read_m && fault)) ? 32'h0 : rdata_dec;

  // Replicate store data across lanes and merge through a byte enable
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = bus.write_data_m;
    case (bus.funct3_m[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << lane;
        wdata_lane = {4{bus.write_data_m[7:0]}};
      end
      2'b01: begin
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{bus.write_data_m[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = wdata_lane[8*i +: 8];
      end
    end
  end

  assign commit = !rst && bus.mem_write_m && !fault;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky <= 1'b0;
      fault_addr   <= 32'h0;
    end else if (fault && !fault_sticky) begin
      fault_sticky <= 1'b1;
      fault_addr   <= addr;
    end
  end
endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL be the number of 32-bit words of storage (4 KiB at default), power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0001_0000, SHALL be the byte address of word 0.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 alu_result_m  input  32  SHALL be the byte address of the access.
REQ-006 write_data_m  input  32  SHALL be the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 mem_write_m  input  1  SHALL request a store when high.
REQ-008 mem_read_m  input  1  SHALL mark a load when high; it only qualifies error detection, since read_data_m is always driven.
REQ-009 funct3_m  input  3  SHALL select size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-010 read_data_m  output  32  SHALL be the load result, extended per funct3_m.
REQ-011 access_fault_m  output  1  SHALL flag, combinationally, a faulting access in the current cycle.
REQ-012 fault_sticky  output  1  SHALL be a registered sticky fault flag.
REQ-013 fault_addr  output  32  SHALL be the registered address of the first fault since reset.

Function
REQ-014 Reads SHALL be combinational: read_data_m reflects storage and inputs in the same cycle, with no extra cycle of latency.
REQ-015 Word index SHALL be (alu_result_m - BASE_ADDR) >> 2; byte lane SHALL be alu_result_m[1:0].
REQ-016 LB/LBU SHALL select the lane byte and sign-extend or zero-extend it to 32 bits; LH/LHU SHALL select the half at lane 0 or 2 and extend it; LW SHALL return the whole word.
REQ-017 Stores SHALL commit at posedge clk when mem_write_m=1 and the access does not fault. SB writes one byte lane, SH writes two byte lanes, SW writes all four; the other lanes are unchanged.
REQ-018 A load in the same cycle as a store to the same word SHALL return the pre-store contents; the new data is visible from the next cycle.
REQ-019 Misalignment SHALL be a fault: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-020 Out-of-range SHALL be a fault: an address below BASE_ADDR, or at or above BASE_ADDR+4*DEPTH_WORDS.
REQ-021 An unsupported funct3_m (011, 110, 111, or 1xx on a store) SHALL be a fault.
REQ-022 access_fault_m SHALL be 1 only when (mem_read_m | mem_write_m) is high and REQ-019, REQ-020 or REQ-021 holds.
REQ-023 A faulting store SHALL leave storage unchanged.
REQ-024 A faulting load SHALL drive read_data_m = 32'h0000_0000.
REQ-025 When mem_read_m=0 and mem_write_m=0, read_data_m SHALL still show the decoded read for an in-range address, and 0 for an out-of-range address.
REQ-026 On the first cycle with access_fault_m=1 and fault_sticky=0, the next posedge SHALL set fault_sticky=1 and load fault_addr with alu_result_m.
REQ-027 Later faults SHALL NOT change fault_addr until reset.
REQ-028 Asserting mem_read_m and mem_write_m together SHALL perform the store per REQ-017 and the read per REQ-018.

Reset
REQ-029 While rst=1 at posedge: fault_sticky <= 0 and fault_addr <= 32'h0.
REQ-030 While rst=1 at posedge, stores SHALL be suppressed; storage contents are otherwise unaffected by reset.
REQ-031 rst SHALL take priority over a simultaneous fault capture.
REQ-032 Storage SHALL have no defined power-up value; the bench writes before it reads.

Verification
REQ-033 SW 32'hDEADBEEF at BASE_ADDR+8, then LW, LBU at +9, LB at +11, LHU at +10 -> read 32'hDEADBEEF, 32'h000000BE, 32'hFFFFFFDE, 32'h0000DEAD.
REQ-034 After REQ-033, SB 8'h12 at +9, then LW +8 -> read 32'hDEAD12EF; SH 16'h8001 at +10, then LH +10 -> read 32'hFFFF8001.
REQ-035 SW 32'h1 and LW at the same address in the same cycle -> the same-cycle read returns the old word and the next cycle returns 32'h1.
REQ-036 LW at BASE_ADDR+2 -> access_fault_m=1 and read_data_m=0; at the next posedge fault_sticky=1 and fault_addr=BASE_ADDR+2. A later SH at +1 -> fault_addr unchanged and storage unchanged.
REQ-037 SW at BASE_ADDR+4*DEPTH_WORDS (out of range) -> fault asserted, no storage word modified; a read of the last valid word (BASE_ADDR+4*DEPTH_WORDS-4) is unchanged.
REQ-038 rst=1 for one cycle while a faulting store is presented -> fault_sticky=0, fault_addr=0, and no write occurs.
